// File: rtl/i2c_byte_shift_engine.sv
// ---------------------------------------------------------------------------
// i2c_byte_shift_engine
//
// Registered I2C master byte engine. It serialises address/data frames onto
// SDA MSB-first, deserialises read frames and handles the ninth (ACK) bit.
// Bit timing comes from one-cycle SCL edge strobes: SDA changes only on fall
// strobes and SDA is sampled only on rise strobes.
//
// Optional feature macro: I2C_10BIT_ADDR_EN
//   When defined, ADDR_SIZE is 10 and an ADDR command sends two frames,
//   {5'b11110, addr[9:8], rw} then addr[7:0]. A NACK on the first frame
//   skips the second frame.
//
// Handshake: a command transfers on a clock edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o is high only in IDLE, and is
// masked for WRITE while tx_valid_i is low. abort_i or reset_i in the same
// cycle cancels the transfer.
//
// Ports
//   i2c_core_clk_i, reset_i        : clock, synchronous active-high reset
//   scl_fall_stb_i, scl_rise_stb_i : SCL edge strobes (drive / sample)
//   cmd_valid_i, cmd_ready_o       : command handshake
//   cmd_i                          : 0 ADDR, 1 WRITE, 2 READ_ACK, 3 READ_NACK
//   rw_i, addr_i                   : R/W bit and slave address for ADDR
//   tx_data_i, tx_valid_i, tx_pop_o: TX FIFO head, not-empty, pop
//   i2c_sda_i, i2c_sda_o           : sampled SDA, SDA drive (1 = release)
//   rx_data_o, rx_valid_o          : received byte, RX FIFO push pulse
//   ack_o                          : last ACK bit (0 = ACK)
//   done_o, busy_o                 : command-complete pulse, frame in flight
//   abort_i                        : synchronous abort
//   dbg_state_o                    : current FSM state (debug)
// ---------------------------------------------------------------------------
module i2c_byte_shift_engine #(
    parameter int DATA_SIZE = 8,
`ifdef I2C_10BIT_ADDR_EN
    parameter int ADDR_SIZE = 10
`else
    parameter int ADDR_SIZE = DATA_SIZE - 1
`endif
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_i,
    input  logic                 scl_fall_stb_i,
    input  logic                 scl_rise_stb_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_i,
    input  logic                 rw_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_pop_o,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 ack_o,
    output logic                 done_o,
    output logic                 busy_o,
    input  logic                 abort_i,
    output logic [1:0]           dbg_state_o
);

    localparam int              CW      = $clog2(DATA_SIZE);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_SIZE - 1);

    localparam logic [1:0] CMD_ADDR     = 2'd0;
    localparam logic [1:0] CMD_WRITE    = 2'd1;
    localparam logic [1:0] CMD_READ_ACK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] shreg_q, shreg_d;
    logic [DATA_SIZE-2:0] rxsh_q, rxsh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [1:0]           cmd_q, cmd_d;
    logic                 sda_q, sda_d;
    logic                 ack_q, ack_d;
    logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 done_q, done_d;
`ifdef I2C_10BIT_ADDR_EN
    logic                 phase_q, phase_d;
    logic [7:0]           addr_lo_q, addr_lo_d;
`endif

    logic                 rise;
    logic                 fall;
    logic                 accept;
    logic                 is_read;
    logic [DATA_SIZE-1:0] addr_frame;
    logic [DATA_SIZE-1:0] rx_byte;

    // A fall strobe coinciding with a rise strobe is dropped.
    assign rise    = scl_rise_stb_i;
    assign fall    = scl_fall_stb_i & ~scl_rise_stb_i;
    assign is_read = cmd_q[1];

    assign cmd_ready_o = (state_q == ST_IDLE) && !((cmd_i == CMD_WRITE) && !tx_valid_i);
    assign accept      = cmd_valid_i & cmd_ready_o & ~abort_i & ~reset_i;
    assign tx_pop_o    = accept & (cmd_i == CMD_WRITE);
    assign rx_byte     = {rxsh_q, i2c_sda_i};

`ifdef I2C_10BIT_ADDR_EN
    assign addr_frame = {5'b11110, addr_i[9:8], rw_i};
`else
    assign addr_frame = {addr_i, rw_i};
`endif

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '1;
            rxsh_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            cmd_q      <= CMD_ADDR;
            sda_q      <= 1'b1;
            ack_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef I2C_10BIT_ADDR_EN
            phase_q    <= 1'b0;
            addr_lo_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rxsh_q     <= rxsh_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            sda_q      <= sda_d;
            ack_q      <= ack_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
`ifdef I2C_10BIT_ADDR_EN
            phase_q    <= phase_d;
            addr_lo_q  <= addr_lo_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        rxsh_d     = rxsh_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        sda_d      = sda_q;
        ack_d      = ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
`ifdef I2C_10BIT_ADDR_EN
        phase_d    = phase_q;
        addr_lo_d  = addr_lo_q;
`endif

        if (abort_i) begin
            state_d = ST_IDLE;
            sda_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The last driven bit (e.g. a master ACK of 0) is held
                    // until the first SCL low phase after the frame.
                    if (fall) sda_d = 1'b1;
                    if (accept) begin
                        cmd_d   = cmd_i;
                        cnt_d   = CNT_MAX;
                        last_d  = 1'b0;
                        state_d = ST_ARM;
`ifdef I2C_10BIT_ADDR_EN
                        phase_d   = 1'b0;
                        addr_lo_d = addr_i[7:0];
`endif
                        case (cmd_i)
                            CMD_ADDR:  shreg_d = addr_frame;
                            CMD_WRITE: shreg_d = tx_data_i;
                            default:   shreg_d = '1;
                        endcase
                    end
                end
                ST_ARM: begin
                    if (fall) begin
                        sda_d   = shreg_q[DATA_SIZE-1];
                        shreg_d = {shreg_q[DATA_SIZE-2:0], 1'b1};
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        rxsh_d = rx_byte[DATA_SIZE-2:0];
                        cnt_d  = cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            last_d = 1'b1;
                            if (is_read) begin
                                rx_data_d  = rx_byte;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (fall) begin
                        if (last_q) begin
                            sda_d   = (cmd_q == CMD_READ_ACK) ? 1'b0 : 1'b1;
                            state_d = ST_ACK;
                        end else begin
                            sda_d   = shreg_q[DATA_SIZE-1];
                            shreg_d = {shreg_q[DATA_SIZE-2:0], 1'b1};
                        end
                    end
                end
                ST_ACK: begin
                    if (rise) begin
                        // For reads the ACK bit is ours, so report what we drove.
                        ack_d   = is_read ? sda_q : i2c_sda_i;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`ifdef I2C_10BIT_ADDR_EN
                        // First address frame ACKed: chain the low address byte.
                        if ((cmd_q == CMD_ADDR) && !phase_q && !i2c_sda_i) begin
                            done_d  = 1'b0;
                            phase_d = 1'b1;
                            shreg_d = addr_lo_q;
                            cnt_d   = CNT_MAX;
                            last_d  = 1'b0;
                            state_d = ST_ARM;
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign i2c_sda_o   = sda_q;
    assign ack_o       = ack_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE) | done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_byte_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_shift_engine
//
// Table of command vectors (command, slave-side bits, expected master SDA
// bits and ACK) applied in a loop, plus hand-written sequences for reset,
// abort, strobe collision, backpressure, IDLE SDA hold and 10-bit address
// chaining. Received bytes go through an expected queue checked on each
// rx_valid_o pulse. Inputs change on the falling clock edge; outputs are
// sampled shortly after it.
// ---------------------------------------------------------------------------
module tb_i2c_byte_shift_engine;

`ifdef I2C_10BIT_ADDR_EN
    localparam int ADDR_W = 10;
`else
    localparam int ADDR_W = 7;
`endif

    localparam logic [1:0] C_ADDR  = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_RACK  = 2'd2;
    localparam logic [1:0] C_RNACK = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       = 1'b1;
    logic              fall_stb  = 1'b0;
    logic              rise_stb  = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_code  = C_ADDR;
    logic              rw_in     = 1'b0;
    logic [ADDR_W-1:0] addr_in   = '0;
    logic [7:0]        tx_data   = 8'h00;
    logic              tx_valid  = 1'b0;
    logic              slave_sda = 1'b1;
    logic              abort     = 1'b0;

    logic       cmd_ready, tx_pop, sda_o, sda_line, rx_valid, ack, done, busy;
    logic [7:0] rx_data;
    logic [1:0] dbg_state;

    // Open-drain bus: either side can pull low.
    assign sda_line = sda_o & slave_sda;

    i2c_byte_shift_engine dut (
        .i2c_core_clk_i (clk),
        .reset_i        (rst),
        .scl_fall_stb_i (fall_stb),
        .scl_rise_stb_i (rise_stb),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_i          (cmd_code),
        .rw_i           (rw_in),
        .addr_i         (addr_in),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_pop_o       (tx_pop),
        .i2c_sda_i      (sda_line),
        .i2c_sda_o      (sda_o),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .ack_o          (ack),
        .done_o         (done),
        .busy_o         (busy),
        .abort_i        (abort),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected no push", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    // One SCL period: fall strobe, slave drives, rise strobe, high phase.
    // Returns the master's SDA drive seen at the rise strobe.
    task automatic bit_period(input logic sb, output logic mb);
        cyc(); fall_stb = 1'b1;
        cyc(); fall_stb = 1'b0; slave_sda = sb;
        cyc(); rise_stb = 1'b1; #1 mb = sda_o;
        cyc(); rise_stb = 1'b0;
    endtask

    task automatic frame(input logic [8:0] slave, output logic [8:0] got);
        logic mb;
        for (int b = 8; b >= 0; b--) begin
            bit_period(slave[b], mb);
            got[b] = mb;
        end
        slave_sda = 1'b1;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] data, input string tag);
        cmd_valid = 1'b1; cmd_code = cmd; rw_in = rw; addr_in = addr;
        tx_data = data; tx_valid = (cmd == C_WRITE);
        #1;
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " pop"}, 32'(tx_pop), 32'(cmd == C_WRITE));
        cyc();
        cmd_valid = 1'b0; tx_valid = 1'b0; cmd_code = C_ADDR;
        #1 check({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, " sda"},      32'(sda_o), 32'd1);
        check({tag, " ack"},      32'(ack), 32'd1);
        check({tag, " ready"},    32'(cmd_ready), 32'd1);
        check({tag, " rx_data"},  32'(rx_data), 32'd0);
        check({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, " done"},     32'(done), 32'd0);
        check({tag, " busy"},     32'(busy), 32'd0);
        check({tag, " pop"},      32'(tx_pop), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]        cmd;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [8:0]        slave;    // slave-side bits, 8..1 data, 0 ACK
        logic [8:0]        exp_bits; // master SDA drive at each rise strobe
        logic              exp_ack;
        int                gap;      // idle clocks before issue; 0 = back-to-back
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        logic [8:0] got;
        int         d0;
        string      tag;
        tag = $sformatf("vec%0d", idx);
        if (v.gap == 0 && idx > 0) check({tag, " done_at_accept"}, 32'(done), 32'd1);
        repeat (v.gap) cyc();
        if (v.cmd[1]) exp_q.push_back(v.slave[8:1]);
        d0 = done_cnt;
        issue(v.cmd, v.rw, v.addr, v.data, tag);
        frame(v.slave, got);
        #2;
        check({tag, " sda_bits"}, 32'(got), 32'(v.exp_bits));
        check({tag, " ack"},      32'(ack), 32'(v.exp_ack));
        check({tag, " done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] rw8, rr8;
        logic [8:0] got;
        logic       mb;
        int         d0;

        rw8 = 8'($urandom_range(0, 255));
        rr8 = 8'($urandom_range(0, 255));
`ifndef I2C_10BIT_ADDR_EN
        vecs.push_back('{C_ADDR,  1'b0, 7'h50, 8'h00, 9'h1FE,        {8'hA0, 1'b1}, 1'b0, 2});
`endif
        vecs.push_back('{C_WRITE, 1'b0, '0,    8'hA5, 9'h1FF,        {8'hA5, 1'b1}, 1'b1, 0});
        vecs.push_back('{C_RACK,  1'b0, '0,    8'h00, {8'h3C, 1'b1}, {8'hFF, 1'b0}, 1'b0, 3});
        vecs.push_back('{C_RNACK, 1'b0, '0,    8'h00, {8'hC3, 1'b1}, {8'hFF, 1'b1}, 1'b1, 0});
`ifndef I2C_10BIT_ADDR_EN
        vecs.push_back('{C_ADDR,  1'b1, 7'h2B, 8'h00, 9'h1FF,        {8'h57, 1'b1}, 1'b1, 1});
`endif
        vecs.push_back('{C_WRITE, 1'b0, '0,    rw8,   9'h1FE,        {rw8, 1'b1},   1'b0, 0});
        vecs.push_back('{C_RNACK, 1'b0, '0,    8'h00, {rr8, 1'b1},   {8'hFF, 1'b1}, 1'b1, 2});

        // Power-on reset
        cyc(); cyc();
        rst = 1'b0;
        #1 reset_check("por");

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: WRITE with empty TX FIFO is not accepted
        cyc();
        cmd_valid = 1'b1; cmd_code = C_WRITE; tx_valid = 1'b0;
        #1;
        check("bp ready", 32'(cmd_ready), 32'd0);
        check("bp pop",   32'(tx_pop), 32'd0);
        cyc();
        cmd_valid = 1'b0; cmd_code = C_ADDR;
        #1 check("bp busy", 32'(busy), 32'd0);

        // Abort after the third bit of a WRITE of 8'h40 (bits 0,1,0)
        d0 = done_cnt;
        issue(C_WRITE, 1'b0, '0, 8'h40, "abort");
        repeat (3) bit_period(1'b1, mb);
        #1 check("abort pre sda", 32'(sda_o), 32'd0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        check("abort sda",  32'(sda_o), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        repeat (3) bit_period(1'b1, mb);
        #2 check("abort no done", 32'(done_cnt), 32'(d0));

        // Collision on the last data bit of a READ_ACK: sample taken, fall
        // dropped (a processed fall would drive the ACK 0 immediately).
        exp_q.push_back(8'h5A);
        d0 = done_cnt;
        issue(C_RACK, 1'b0, '0, 8'h00, "coll");
        for (int b = 7; b >= 1; b--) bit_period(rr8[0] ^ rr8[0] ^ (8'h5A >> b) & 1'b1, mb);
        cyc(); fall_stb = 1'b1;
        cyc(); fall_stb = 1'b0; slave_sda = 1'b0;
        cyc(); fall_stb = 1'b1; rise_stb = 1'b1;
        cyc(); fall_stb = 1'b0; rise_stb = 1'b0; slave_sda = 1'b1;
        #1 check("coll sda held", 32'(sda_o), 32'd1);
        bit_period(1'b1, mb);
        check("coll ack drive", 32'(mb), 32'd0);
        #2;
        check("coll done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("coll ack",      32'(ack), 32'd0);
        check("idle hold sda", 32'(sda_o), 32'd0);
        bit_period(1'b1, mb);
        check("idle release sda", 32'(mb), 32'd1);

        // Reset held for two clocks in the middle of a WRITE
        d0 = done_cnt;
        issue(C_WRITE, 1'b0, '0, 8'h00, "rst");
        repeat (3) bit_period(1'b1, mb);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1 reset_check("midrst");
        repeat (2) begin
            bit_period(1'b1, mb);
            check("midrst quiet sda", 32'(mb), 32'd1);
        end
        #2;
        check("midrst no done", 32'(done_cnt), 32'(d0));
        check("midrst busy",    32'(busy), 32'd0);

`ifdef I2C_10BIT_ADDR_EN
        // 10-bit address 10'h2A5, read: frames 8'hF5 then 8'hA5
        d0 = done_cnt;
        issue(C_ADDR, 1'b1, 10'h2A5, 8'h00, "a10");
        frame(9'h1FE, got);
        #2;
        check("a10 f1 bits", 32'(got), 32'({8'hF5, 1'b1}));
        check("a10 f1 no done", 32'(done_cnt), 32'(d0));
        check("a10 f1 busy", 32'(busy), 32'd1);
        frame(9'h1FE, got);
        #2;
        check("a10 f2 bits", 32'(got), 32'({8'hA5, 1'b1}));
        check("a10 done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("a10 ack", 32'(ack), 32'd0);
        // NACK on frame 1 ends the command without frame 2
        issue(C_ADDR, 1'b1, 10'h2A5, 8'h00, "a10n");
        frame(9'h1FF, got);
        #2;
        check("a10n bits", 32'(got), 32'({8'hF5, 1'b1}));
        check("a10n done_cnt", 32'(done_cnt), 32'(d0 + 2));
        check("a10n ack", 32'(ack), 32'd1);
        bit_period(1'b1, mb);
        #2 check("a10n idle", 32'(busy), 32'd0);
`endif

        repeat (3) cyc();
        check("rx queue drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
